pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 112 +++++++++++
 tb/tb_pipe_skid_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer for a pipeline stage boundary.
// Both handshake outputs are flops, so neither in_ready_o nor out_valid_o
// has a combinational path from the opposite side of the stage. The skid
// entry absorbs the one payload that can still arrive in the cycle after
// the downstream stage stalls.
module pipe_skid_reg #(
  parameter int DATA_W    = 64,
  parameter bit FLUSH_CLR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  // The state encoding is also the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Next-state and payload-load decisions; registers hold unless a listed transition loads them.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data_i;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          // Main keeps its content on drain; out_data_o is don't-care while invalid.
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready_o is low here, so only the downstream side can move.
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush overrides everything: an output fire in the same cycle has
    // already been consumed downstream, and any input payload is dropped.
    if (flush_i) begin
      state_d = EMPTY;
      if (FLUSH_CLR) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State, payload and registered handshake outputs; reset aborts in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;
  assign count_o     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized checks of pipe_skid_reg (DATA_W=8)
// against a two-deep FIFO reference model with flush.
module tb_pipe_skid_reg;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO of accepted payloads, capacity 2.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] model_delivered[$];
  logic [DATA_W-1:0] dut_delivered[$];

  pipe_skid_reg #(
    .DATA_W    (DATA_W),
    .FLUSH_CLR (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready_o), 64'(mq.size() < 2));
    chk("count", 64'(count_o), 64'(mq.size()));
    if (mq.size() > 0) chk("out_data", 64'(out_data_o), 64'(mq[0]));
  endtask

  // Called just after a falling edge: apply inputs, advance one rising edge,
  // update the model, then check at the next falling edge.
  task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    bit                ofire;
    bit                ifire;
    bit                hold;
    logic [DATA_W-1:0] held;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    #1;
    hold = out_valid_o && !r;
    held = out_data_o;
    if (out_valid_o && r) dut_delivered.push_back(out_data_o);
    @(posedge clk);
    ofire = (mq.size() > 0) && r;
    ifire = (mq.size() < 2) && v;
    if (ofire) model_delivered.push_back(mq[0]);
    if (f) begin
      mq.delete();
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(d);
    end
    @(negedge clk);
    check_outputs();
    if (hold && !f) chk("stable", 64'(out_data_o), 64'(held));
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hAA;
    out_ready_i = 1'b0;

    // Reset held low with an upstream payload offered.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'h00);
    in_valid_i = 1'b0;
    rst_n      = 1'b1;

    // Streaming 01..08 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b1, 1'b0);
      chk("stream_count", 64'(count_o), 64'd1);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: 10, 11 accepted, 12 held upstream until room.
    drive_cycle(1'b1, 8'h10, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    chk("bp_count_full", 64'(count_o), 64'd2);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    drive_cycle(1'b1, 8'h12, 1'b0, 1'b0);
    chk("bp_hold_data", 64'(out_data_o), 64'h10);
    drive_cycle(1'b1, 8'h12, 1'b1, 1'b0);
    chk("bp_second", 64'(out_data_o), 64'h11);
    drive_cycle(1'b1, 8'h12, 1'b1, 1'b0);
    chk("bp_third", 64'(out_data_o), 64'h12);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush in FULL with a payload offered in the same cycle.
    drive_cycle(1'b1, 8'h31, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h32, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_main_clr", 64'(out_data_o), 64'h00);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush coinciding with an output fire in BUSY.
    drive_cycle(1'b1, 8'h20, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("flush_fire_count", 64'(count_o), 64'd0);
    chk("flush_fire_deliv", 64'(dut_delivered[dut_delivered.size()-1]), 64'h20);

    // Reset asserted mid-operation takes effect without a clock edge.
    drive_cycle(1'b1, 8'h41, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h42, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_ready", 64'(in_ready_o), 64'd1);
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_data", 64'(out_data_o), 64'h00);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 8'h43, 1'b1, 1'b0);
    chk("post_rst_data", 64'(out_data_o), 64'h43);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      drive_cycle(bit'($urandom_range(0, 99) < 70),
                  8'($urandom),
                  bit'($urandom_range(0, 99) < 60),
                  bit'($urandom_range(0, 99) < 3));
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Scoreboard: everything the DUT handed downstream, in order.
    chk("deliv_len", 64'(dut_delivered.size()), 64'(model_delivered.size()));
    for (int i = 0; i < dut_delivered.size() && i < model_delivered.size(); i++) begin
      if (dut_delivered[i] !== model_delivered[i])
        chk("deliv_item", 64'(dut_delivered[i]), 64'(model_delivered[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
